jk_mod_counter: RTL and testbench

//  Synchronous modulo-N up/down counter built from JK flip-flop cells. It sits directly downstream of the lab's JK flip-flop.
//  - Per-bit J/K excitation is derived from the current and next count. Each cell's Q feeds back into that logic.
//  - Exposes count, terminal-count and raw J/K excitation for waveform inspection.

---
 rtl/jk_pkg.sv | 28 ++
 rtl/jk_cell.sv | 31 +++
 rtl/jk_mod_counter.sv | 81 ++++++++
 tb/tb_jk_mod_counter.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// Shared JK flip-flop definitions: operation encoding and the excitation helper
// that maps a (current, next) bit pair onto the J/K inputs.
package jk_pkg;

  // Encoding equals the {J,K} pair that requests the operation.
  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_op_t;

  function automatic jk_op_t jk_op(input logic cur, input logic nxt);
    jk_op_t op;
    case ({cur, nxt})
      2'b01:   op = JK_SET;
      2'b10:   op = JK_RESET;
      default: op = JK_HOLD;
    endcase
    return op;
  endfunction

  // Returns {J,K}; toggle is never produced, only set/reset/hold.
  function automatic logic [1:0] jk_encode(input logic cur, input logic nxt);
    return 2'(jk_op(cur, nxt));
  endfunction

endpackage

// File: rtl/jk_cell.sv
// Single edge-triggered JK flip-flop with asynchronous active-low reset.
module jk_cell
  import jk_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_r;

  // JK state update: hold, reset, set or toggle on the rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r <= 1'b0;
    end else begin
      case ({j, k})
        JK_HOLD:   q_r <= q_r;
        JK_RESET:  q_r <= 1'b0;
        JK_SET:    q_r <= 1'b1;
        JK_TOGGLE: q_r <= ~q_r;
        default:   q_r <= q_r;
      endcase
    end
  end

  assign q = q_r;

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-N up/down counter built from W JK cells. Optional parallel load is
// enabled by defining JK_CNT_LOAD_EN; otherwise load/d are ignored.
module jk_mod_counter
  import jk_pkg::*;
#(
  parameter int W = 4,
  parameter int N = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         up,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         tc,
  output logic [W-1:0] j,
  output logic [W-1:0] k
);

  localparam logic [W-1:0] MAX_C  = W'(N - 1);
  localparam logic [W-1:0] ZERO_C = {W{1'b0}};
  localparam logic [W-1:0] ONE_C  = W'(1);

  logic [W-1:0] q_s;
  logic [W-1:0] next_s;
  logic [W-1:0] j_s;
  logic [W-1:0] k_s;

  // Next count: out-of-range values wrap to 0 going up, decrement going down.
  always_comb begin
    next_s = q_s;
`ifdef JK_CNT_LOAD_EN
    if (load) begin
      next_s = d;
    end else if (en) begin
`else
    if (en) begin
`endif
      if (up) begin
        if (q_s >= MAX_C) next_s = ZERO_C;
        else              next_s = q_s + ONE_C;
      end else begin
        if (q_s == ZERO_C) next_s = MAX_C;
        else               next_s = q_s - ONE_C;
      end
    end else begin
      next_s = q_s;
    end
  end

`ifndef JK_CNT_LOAD_EN
  logic unused_load_s;
  assign unused_load_s = ^{load, d};
`endif

  // Per-bit excitation derived from current and next count.
  always_comb begin
    j_s = ZERO_C;
    k_s = ZERO_C;
    for (int i = 0; i < W; i++) begin
      {j_s[i], k_s[i]} = jk_encode(q_s[i], next_s[i]);
    end
  end

  for (genvar g = 0; g < W; g++) begin : g_cell
    jk_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .j     (j_s[g]),
      .k     (k_s[g]),
      .q     (q_s[g])
    );
  end

  assign tc = en & ((up & (q_s == MAX_C)) | (~up & (q_s == ZERO_C)));
  assign q  = q_s;
  assign j  = j_s;
  assign k  = k_s;

endmodule

// File: tb/tb_jk_mod_counter.sv
// Directed self-checking bench for jk_mod_counter (W=4, N=10); load tests run
// only when JK_CNT_LOAD_EN is defined, otherwise load is checked to be ignored.
module tb_jk_mod_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       up = 1'b1;
  logic       load = 1'b0;
  logic [3:0] d = 4'd0;
  logic [3:0] q;
  logic       tc;
  logic [3:0] j;
  logic [3:0] k;

  int tests = 0;
  int fails = 0;

  jk_mod_counter #(.W(4), .N(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .up    (up),
    .load  (load),
    .d     (d),
    .q     (q),
    .tc    (tc),
    .j     (j),
    .k     (k)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Excitation invariants checked every cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("jk_excl", 32'(j & k), 32'd0);
      chk("j_vs_q", 32'(j & q), 32'd0);
      chk("k_vs_q", 32'(k & ~q), 32'd0);
    end
  end

  initial begin
    int up_exp [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};

    // Reset state
    #12;
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_tc", 32'(tc), 32'd0);
    chk("rst_j", 32'(j), 32'd0);
    rst_n = 1'b1;
    en = 1'b1;
    up = 1'b1;
    #1;
    chk("up0_j", 32'(j), 32'h1);
    chk("up0_k", 32'(k), 32'h0);

    // Test 1: count up through the wrap
    for (int i = 0; i < 12; i++) begin
      step();
      chk("up_q", 32'(q), 32'(up_exp[i]));
      chk("up_tc", 32'(tc), (up_exp[i] == 9) ? 32'd1 : 32'd0);
      if (i == 8) begin
        chk("wrap_j", 32'(j), 32'h0);
        chk("wrap_k", 32'(k), 32'h9);
      end
    end

    // Test 2: reset between edges, then count down
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst2_q", 32'(q), 32'd0);
    rst_n = 1'b1;
    up = 1'b0;
    #1;
    chk("dn0_tc", 32'(tc), 32'd1);
    chk("dn0_j", 32'(j), 32'h9);
    chk("dn0_k", 32'(k), 32'h0);
    step(); chk("dn_q9", 32'(q), 32'd9); chk("dn_tc9", 32'(tc), 32'd0);
    step(); chk("dn_q8", 32'(q), 32'd8);
    step(); chk("dn_q7", 32'(q), 32'd7);
    step(); step(); step();
    chk("dn_q4", 32'(q), 32'd4);

    // Test 3: hold
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_q", 32'(q), 32'd4);
      chk("hold_j", 32'(j), 32'h0);
      chk("hold_k", 32'(k), 32'h0);
      chk("hold_tc", 32'(tc), 32'd0);
    end

    // Test 4: load beats enable (or is ignored without the load path)
    en = 1'b1;
    up = 1'b1;
    load = 1'b1;
    d = 4'd6;
    step();
`ifdef JK_CNT_LOAD_EN
    chk("ld6_q", 32'(q), 32'd6);
    load = 1'b0;
    step();
    chk("ld6_next", 32'(q), 32'd7);
`else
    chk("noload_q", 32'(q), 32'd5);
    load = 1'b0;
    step();
    chk("noload_next", 32'(q), 32'd6);
    step();
    chk("noload_q7", 32'(q), 32'd7);
`endif

    // Test 6: asynchronous reset pulse between edges at Q=7
    #2;
    rst_n = 1'b0;
    #3;
    chk("async_rst_q", 32'(q), 32'd0);
    rst_n = 1'b1;
    step(); chk("resume_q1", 32'(q), 32'd1);
    step(); chk("resume_q2", 32'(q), 32'd2);

    // Test 5: out-of-range load
    load = 1'b1;
    d = 4'd12;
    up = 1'b1;
    step();
`ifdef JK_CNT_LOAD_EN
    chk("oor_up_q", 32'(q), 32'd12);
    chk("oor_up_tc", 32'(tc), 32'd0);
    load = 1'b0;
    step();
    chk("oor_up_wrap", 32'(q), 32'd0);
    load = 1'b1;
    up = 1'b0;
    step();
    chk("oor_dn_q", 32'(q), 32'd12);
    load = 1'b0;
    step(); chk("oor_dn_11", 32'(q), 32'd11);
    step(); chk("oor_dn_10", 32'(q), 32'd10);
    step(); chk("oor_dn_9", 32'(q), 32'd9);
`else
    chk("noload_oor_q", 32'(q), 32'd3);
    load = 1'b0;
    up = 1'b0;
    step();
    chk("noload_dn_q", 32'(q), 32'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
